// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer driving one shared external
// 1-bit full-adder cell, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the `sub` port. When it is
// asserted at start, the block computes op_a - op_b (two's complement).
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout_out,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  input  logic         fa_s,
  input  logic         fa_cout
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LastBit = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  sum_sr_q, sum_sr_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  // Operand B and the initial carry as they enter the shift path.
  // Subtraction is the usual A + ~B + 1.
  logic [W-1:0]  bLoad;
  logic          cLoad;

  // Pick the operand-B and carry load values for the configured feature set.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    bLoad = sub ? ~op_b : op_b;
    cLoad = sub ? 1'b1  : cin_in;
`else
    bLoad = op_b;
    cLoad = cin_in;
`endif
  end

  // State register. Reset aborts any operation in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. The cell inputs come straight from registers and are
  // gated to zero outside RUN.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    fa_a   = (state_q == RUN) & a_sr_q[0];
    fa_b   = (state_q == RUN) & b_sr_q[0];
    fa_cin = (state_q == RUN) & carry_q;
  end

  // Datapath next-state: load on an accepted start, then shift one bit per cycle.
  // The result is published on the last bit.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (state_q == IDLE && start) begin
      a_sr_d   = op_a;
      b_sr_d   = bLoad;
      sum_sr_d = '0;
      carry_d  = cLoad;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      sum_sr_d = {fa_s, sum_sr_q[W-1:1]};
      carry_d  = fa_cout;
      a_sr_d   = {1'b0, a_sr_q[W-1:1]};
      b_sr_d   = {1'b0, b_sr_q[W-1:1]};
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LastBit) begin
        sum_d  = {fa_s, sum_sr_q[W-1:1]};
        cout_d = fa_cout;
      end
    end
  end

  // Datapath registers. Reset clears them all, including the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign sum      = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of serial_adder_ctrl at W=8 with a
// behavioural full-adder cell. Define SERIAL_ADDER_SUB_EN to also cover
// subtraction.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         cinIn;
  logic         subIn;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         coutOut;
  logic         faA;
  logic         faB;
  logic         faCin;
  logic         faS;
  logic         faCout;

  int checks;
  int errors;

  serial_adder_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (opA),
    .op_b     (opB),
    .cin_in   (cinIn),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (subIn),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout_out (coutOut),
    .fa_a     (faA),
    .fa_b     (faB),
    .fa_cin   (faCin),
    .fa_s     (faS),
    .fa_cout  (faCout)
  );

  // The shared external 1-bit full-adder cell.
  assign faS    = faA ^ faB ^ faCin;
  assign faCout = (faA & faB) | (faA & faCin) | (faB & faCin);

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Run one complete operation from an accepted start through the DONE cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s,
                               input logic [W-1:0] expSum, input logic expCout,
                               input string tag);
    opA = a; opB = b; cinIn = c; subIn = s; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    opA = ~a; opB = ~b; cinIn = ~c;           // operands are free to change now
    checkOutput({tag, " busy@E0"}, busy, 1);
    checkOutput({tag, " fa_a bit0"}, faA, a[0]);
    checkOutput({tag, " fa_b bit0"}, faB, s ? ~b[0] : b[0]);
    checkOutput({tag, " fa_cin bit0"}, faCin, s ? 1'b1 : c);
    for (int i = 1; i < W; i++) begin
      tick();                                 // E1..E7
      checkOutput({tag, " done early"}, done, 0);
      checkOutput({tag, " busy mid"}, busy, 1);
    end
    tick();                                   // E8
    checkOutput({tag, " done@E8"}, done, 1);
    checkOutput({tag, " busy@E8"}, busy, 1);
    checkOutput({tag, " sum"}, sum, expSum);
    checkOutput({tag, " cout"}, coutOut, expCout);
    checkOutput({tag, " fa idle in DONE"}, {faA, faB, faCin}, 0);
    tick();                                   // E9
    checkOutput({tag, " done@E9"}, done, 0);
    checkOutput({tag, " busy@E9"}, busy, 0);
    checkOutput({tag, " sum held"}, sum, expSum);
    checkOutput({tag, " cout held"}, coutOut, expCout);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; opA = '0; opB = '0; cinIn = 1'b0; subIn = 1'b0;

    // Reset state.
    tick();
    tick();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", coutOut, 0);
    checkOutput("reset fa", {faA, faB, faCin}, 0);
    rst_n = 1'b1;
    tick();

    // Basic additions and carry-out boundaries.
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add5A3C");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "addFF01");
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "addFF00c1");

    // A start while busy is ignored, both mid-RUN and in DONE.
    opA = 8'h12; opB = 8'h34; cinIn = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0; opA = 8'hFF; opB = 8'hFF;
    tick(); tick();                           // E1, E2
    start = 1'b1;
    tick();                                   // E3 samples start in RUN
    start = 1'b0;
    for (int i = 4; i < W; i++) tick();       // E4..E7
    checkOutput("ignore done early", done, 0);
    tick();                                   // E8
    checkOutput("ignore done@E8", done, 1);
    checkOutput("ignore sum", sum, 8'h46);
    checkOutput("ignore cout", coutOut, 0);
    start = 1'b1;
    tick();                                   // E9 samples start in DONE
    start = 1'b0;
    checkOutput("ignore busy@E9", busy, 0);
    tick();                                   // E10
    checkOutput("ignore not queued busy", busy, 0);
    checkOutput("ignore not queued done", done, 0);
    checkOutput("ignore sum kept", sum, 8'h46);

    // Reset in the middle of RUN aborts with no done pulse.
    opA = 8'hAA; opB = 8'h55; cinIn = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick(); tick(); tick();                   // E1..E3
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort sum", sum, 0);
    checkOutput("abort cout", coutOut, 0);
    checkOutput("abort fa", {faA, faB, faCin}, 0);
    tick();                                   // E4 held in reset
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      checkOutput("abort no done", done, 0);
      checkOutput("abort stays idle", busy, 0);
    end
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "after abort");

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: cout_out=1 means no borrow; cin_in is ignored.
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub1001");
    applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, "sub0102");
    applyStimulus(8'h20, 8'h03, 1'b1, 1'b0, 8'h24, 1'b0, "sub0 adds");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
